// File: rtl/alarm_pkg.sv
// Shared types and BCD limits for the alarm ring controller.
// Used by alarm_ring_ctrl and alarm_bcd_time_reg.
package alarm_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SET      = 3'd1,
        ARMED_ST = 3'd2,
        RINGING  = 3'd3,
        SNOOZE   = 3'd4
    } alarm_state_e;

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_SET     = SET;
    localparam logic [2:0] S_ARMED   = ARMED_ST;
    localparam logic [2:0] S_RINGING = RINGING;
    localparam logic [2:0] S_SNOOZE  = SNOOZE;

    localparam logic [3:0] MIN_H_MAX       = 4'd5;
    localparam logic [3:0] MIN_L_MAX       = 4'd9;
    localparam logic [3:0] HOUR_H_MAX      = 4'd2;
    localparam logic [3:0] HOUR_L_MAX_AT_2 = 4'd3;
    localparam logic [3:0] DIGIT_MAX       = 4'd9;

    function automatic logic [3:0] bcd_inc(
        input logic [3:0] d,
        input logic [3:0] max
    );
        return (d == max) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/alarm_bcd_time_reg.sv
// Alarm-time BCD digits (HH:MM) with wrap-correct increments.
// Minutes wrap 59->00 without carrying into hours; hours wrap 23->00.
module alarm_bcd_time_reg
    import alarm_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_inc_min,
    input  logic       i_inc_hour,
    output logic [3:0] o_min_l,
    output logic [3:0] o_min_h,
    output logic [3:0] o_hour_l,
    output logic [3:0] o_hour_h
);

    logic [3:0] r_min_l;
    logic [3:0] r_min_h;
    logic [3:0] r_hour_l;
    logic [3:0] r_hour_h;

    logic w_min_l_top;
    logic w_hour_top;
    logic w_hour_l_top;

    assign w_min_l_top  = (r_min_l == MIN_L_MAX);
    assign w_hour_l_top = (r_hour_l == DIGIT_MAX);
    assign w_hour_top   = (r_hour_h == HOUR_H_MAX)
                       && (r_hour_l == HOUR_L_MAX_AT_2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_min_l  <= 4'd0;
            r_min_h  <= 4'd0;
            r_hour_l <= 4'd0;
            r_hour_h <= 4'd0;
        end else begin
            if (i_inc_min) begin
                r_min_l <= bcd_inc(r_min_l, MIN_L_MAX);
                if (w_min_l_top)
                    r_min_h <= bcd_inc(r_min_h, MIN_H_MAX);
            end
            if (i_inc_hour) begin
                if (w_hour_top) begin
                    r_hour_l <= 4'd0;
                    r_hour_h <= 4'd0;
                end else begin
                    r_hour_l <= bcd_inc(r_hour_l, DIGIT_MAX);
                    if (w_hour_l_top)
                        r_hour_h <= r_hour_h + 4'd1;
                end
            end
        end
    end

    assign o_min_l  = r_min_l;
    assign o_min_h  = r_min_h;
    assign o_hour_l = r_hour_l;
    assign o_hour_h = r_hour_h;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring/snooze/timeout sequencer and alarm-time owner.
// Optional ALARM_BUZZ_PATTERN_EN: BUZZ beeps at 0.5 Hz while ringing.
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int CNT_W       = 9
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick_1hz,
    input  logic       i_btn_set,
    input  logic       i_btn_inc_min,
    input  logic       i_btn_inc_hour,
    input  logic       i_btn_arm,
    input  logic       i_btn_stop,
    input  logic       i_btn_snooze,
    input  logic       i_match,
    output logic [3:0] o_set_min_l,
    output logic [3:0] o_set_min_h,
    output logic [3:0] o_set_hour_l,
    output logic [3:0] o_set_hour_h,
    output logic       o_en_setalarm,
    output logic       o_armed,
    output logic       o_ring,
    output logic       o_buzz
);

    localparam logic [CNT_W-1:0] RING_END   = CNT_W'(RING_SECS);
    localparam logic [CNT_W-1:0] SNOOZE_END = CNT_W'(SNOOZE_SECS);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_match_d;
    logic             r_en;
    logic             r_armed;
    logic             r_ring;
    logic             r_buzz;

    logic [2:0]       w_next;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_rise;
    logic             w_buzz_nxt;
    logic             w_in_set;

    assign w_rise    = i_match & ~r_match_d;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_in_set  = (r_state == S_SET);

    alarm_bcd_time_reg u_time (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_inc_min  (i_btn_inc_min & w_in_set),
        .i_inc_hour (i_btn_inc_hour & w_in_set),
        .o_min_l    (o_set_min_l),
        .o_min_h    (o_set_min_h),
        .o_hour_l   (o_set_hour_l),
        .o_hour_h   (o_set_hour_h)
    );

    // Any exit from RINGING/SNOOZE clears the counter, so it never wraps.
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_btn_set)
                    w_next = S_SET;
                else if (i_btn_arm)
                    w_next = S_ARMED;
            end
            S_SET: begin
                if (i_btn_set)
                    w_next = S_IDLE;
            end
            S_ARMED: begin
                if (i_btn_arm)
                    w_next = S_IDLE;
                else if (i_btn_set)
                    w_next = S_SET;
                else if (w_rise) begin
                    w_next    = S_RINGING;
                    w_cnt_nxt = '0;
                end
            end
            S_RINGING: begin
                if (i_btn_arm) begin
                    w_next    = S_IDLE;
                    w_cnt_nxt = '0;
                end else if (i_btn_stop) begin
                    w_next    = S_ARMED;
                    w_cnt_nxt = '0;
                end else if (i_btn_snooze) begin
                    w_next    = S_SNOOZE;
                    w_cnt_nxt = '0;
                end else if (i_tick_1hz) begin
                    if (w_cnt_inc == RING_END) begin
                        w_next    = S_ARMED;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            S_SNOOZE: begin
                if (i_btn_arm) begin
                    w_next    = S_IDLE;
                    w_cnt_nxt = '0;
                end else if (i_btn_stop) begin
                    w_next    = S_ARMED;
                    w_cnt_nxt = '0;
                end else if (i_tick_1hz) begin
                    if (w_cnt_inc == SNOOZE_END) begin
                        w_next    = S_RINGING;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_next    = S_IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

`ifdef ALARM_BUZZ_PATTERN_EN
    always_comb begin
        w_buzz_nxt = 1'b0;
        if (w_next == S_RINGING) begin
            if (r_state != S_RINGING)
                w_buzz_nxt = 1'b1;
            else if (i_tick_1hz)
                w_buzz_nxt = ~r_buzz;
            else
                w_buzz_nxt = r_buzz;
        end
    end
`else
    assign w_buzz_nxt = (w_next == S_RINGING);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_match_d <= 1'b0;
            r_en      <= 1'b0;
            r_armed   <= 1'b0;
            r_ring    <= 1'b0;
            r_buzz    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_nxt;
            r_match_d <= i_match;
            r_en      <= (w_next == S_SET);
            r_armed   <= (w_next == S_ARMED)
                      || (w_next == S_RINGING)
                      || (w_next == S_SNOOZE);
            r_ring    <= (w_next == S_RINGING);
            r_buzz    <= w_buzz_nxt;
        end
    end

    assign o_en_setalarm = r_en;
    assign o_armed       = r_armed;
    assign o_ring        = r_ring;
    assign o_buzz        = r_buzz;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Scoreboard bench for alarm_ring_ctrl (RING_SECS=3, SNOOZE_SECS=2).
// Honours ALARM_BUZZ_PATTERN_EN for the expected BUZZ sequence.
module tb_alarm_ring_ctrl;

    localparam logic [5:0] B_SET = 6'd1;
    localparam logic [5:0] B_MIN = 6'd2;
    localparam logic [5:0] B_HR  = 6'd4;
    localparam logic [5:0] B_ARM = 6'd8;
    localparam logic [5:0] B_STP = 6'd16;
    localparam logic [5:0] B_SNZ = 6'd32;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [5:0] btn;
    logic       match;
    logic [3:0] min_l;
    logic [3:0] min_h;
    logic [3:0] hour_l;
    logic [3:0] hour_h;
    logic       en;
    logic       armed;
    logic       ring;
    logic       buzz;

    typedef struct {
        string       tag;
        logic [3:0]  fl;
        logic [15:0] tm;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   e_min = 0;
    int   e_hour = 0;
    logic e_in_set = 1'b0;

    alarm_ring_ctrl #(
        .RING_SECS   (3),
        .SNOOZE_SECS (2),
        .CNT_W       (9)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_tick_1hz     (tick),
        .i_btn_set      (btn[0]),
        .i_btn_inc_min  (btn[1]),
        .i_btn_inc_hour (btn[2]),
        .i_btn_arm      (btn[3]),
        .i_btn_stop     (btn[4]),
        .i_btn_snooze   (btn[5]),
        .i_match        (match),
        .o_set_min_l    (min_l),
        .o_set_min_h    (min_h),
        .o_set_hour_l   (hour_l),
        .o_set_hour_h   (hour_h),
        .o_en_setalarm  (en),
        .o_armed        (armed),
        .o_ring         (ring),
        .o_buzz         (buzz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic pbz(input logic r, input logic p);
`ifdef ALARM_BUZZ_PATTERN_EN
        return p;
`else
        return r;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({e.tag, ".flags"}, {12'd0, en, armed, ring, buzz},
                {12'd0, e.fl});
            chk({e.tag, ".time"}, {hour_h, hour_l, min_h, min_l}, e.tm);
        end
    endtask

    task automatic push(input string tag, input logic ee, input logic ea,
                        input logic er, input logic eb);
        sbq.push_back('{tag, {ee, ea, er, eb}, bcd(e_hour, e_min)});
    endtask

    task automatic step(input string tag, input logic [5:0] b,
                        input logic t, input logic m,
                        input logic ee, input logic ea,
                        input logic er, input logic pb);
        @(negedge clk);
        btn   = b;
        tick  = t;
        match = m;
        if (e_in_set && b[1]) e_min = (e_min + 1) % 60;
        if (e_in_set && b[2]) e_hour = (e_hour + 1) % 24;
        push(tag, ee, ea, er, pbz(er, pb));
        e_in_set = ee;
        @(posedge clk);
        #1;
        btn  = 6'd0;
        tick = 1'b0;
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 6'd0;
        tick  = 1'b0;
        match = 1'b0;
        #12;
        push("reset", 0, 0, 0, 0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;

        step("set_on", B_SET, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 61; i++)
            step("inc_min", B_MIN, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 25; i++)
            step("inc_hour", B_HR, 0, 0, 1, 0, 0, 0);
        step("arm_in_set", B_ARM, 0, 0, 1, 0, 0, 0);
        step("set_off", B_SET, 0, 0, 0, 0, 0, 0);
        step("idle_inc", B_MIN | B_HR, 0, 0, 0, 0, 0, 0);
        step("set_on2", B_SET, 0, 0, 1, 0, 0, 0);
        step("inc_both", B_MIN | B_HR, 0, 0, 1, 0, 0, 0);
        step("set_off2", B_SET, 0, 0, 0, 0, 0, 0);

        step("arm", B_ARM, 0, 0, 0, 1, 0, 0);
        step("rise1", 0, 0, 1, 0, 1, 1, 1);
        step("ring_t1", 0, 1, 1, 0, 1, 1, 0);
        step("ring_t2", 0, 1, 1, 0, 1, 1, 1);
        step("ring_t3", 0, 1, 1, 0, 1, 0, 0);
        step("hold_hi1", 0, 0, 1, 0, 1, 0, 0);
        step("hold_hi2", 0, 1, 1, 0, 1, 0, 0);
        step("match_lo", 0, 0, 0, 0, 1, 0, 0);

        step("rise2", 0, 0, 1, 0, 1, 1, 1);
        step("snooze", B_SNZ, 0, 1, 0, 1, 0, 0);
        step("snz_lo", 0, 0, 0, 0, 1, 0, 0);
        step("snz_t1", 0, 1, 0, 0, 1, 0, 0);
        step("snz_t2", 0, 1, 0, 0, 1, 1, 1);
        step("stop_snz", B_STP | B_SNZ, 0, 0, 0, 1, 0, 0);

        step("rise3", 0, 0, 1, 0, 1, 1, 1);
        step("tick_stop", B_STP, 1, 1, 0, 1, 0, 0);
        step("lo3", 0, 0, 0, 0, 1, 0, 0);
        step("rise4", 0, 0, 1, 0, 1, 1, 1);
        step("r4_t1", 0, 1, 1, 0, 1, 1, 0);
        step("r4_t2", 0, 1, 1, 0, 1, 1, 1);
        step("tick_snz", B_SNZ, 1, 1, 0, 1, 0, 0);
        step("s4_t1", 0, 1, 0, 0, 1, 0, 0);
        step("s4_t2", 0, 1, 0, 0, 1, 1, 1);
        step("arm_ring", B_ARM, 0, 0, 0, 0, 0, 0);

        step("rearm", B_ARM, 0, 0, 0, 1, 0, 0);
        step("arm_vs_rise", B_ARM, 0, 1, 0, 0, 0, 0);
        step("idle_hi", 0, 0, 1, 0, 0, 0, 0);
        step("arm_hi", B_ARM, 0, 1, 0, 1, 0, 0);
        step("hi_no_ring", 0, 0, 1, 0, 1, 0, 0);
        step("set_arm", B_SET, 0, 0, 1, 0, 0, 0);
        step("set_back", B_SET, 0, 0, 0, 0, 0, 0);
        step("arm3", B_ARM, 0, 0, 0, 1, 0, 0);
        step("rise5", 0, 0, 1, 0, 1, 1, 1);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        e_min  = 0;
        e_hour = 0;
        push("async_rst", 0, 0, 0, 0);
        drain();
        @(posedge clk);
        #1;
        push("rst_hold", 0, 0, 0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
